// File: rtl/hex_scan_if.sv
// hex_scan_if -- bundle between a display client and hex_scan_driver.
//   value      client -> driver  DIGITS hex nibbles, digit 0 = least significant
//   load       client -> driver  capture value into the driver's shadow register
//   blank_lz   client -> driver  enable leading-zero blanking
//   blink_en   client -> driver  enable whole-display blink
//   seg_out    driver -> pins    {g,f,e,d,c,b,a}, active-low
//   digit_sel  driver -> pins    digit enables, active-low one-hot
//   frame_tick driver -> client  one-cycle pulse at each scan wrap to digit 0
interface hex_scan_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic                load;
    logic                blank_lz;
    logic                blink_en;
    logic [6:0]          seg_out;
    logic [DIGITS-1:0]   digit_sel;
    logic                frame_tick;

    modport master (
        output value, load, blank_lz, blink_en,
        input  seg_out, digit_sel, frame_tick
    );

    modport slave (
        input  value, load, blank_lz, blink_en,
        output seg_out, digit_sel, frame_tick
    );
endinterface

// File: rtl/hex_scan_driver.sv
// hex_scan_driver -- time-multiplexed driver for DIGITS common-anode 7-segment
// hex digits sharing one active-low segment bus.
//   clk  system clock, all state changes on the rising edge
//   rst  synchronous active-high reset, overrides load and all counting
//   bus  hex_scan_if slave: value/load/blank_lz/blink_en in,
//        seg_out/digit_sel/frame_tick out (all outputs registered)
// Each digit stays selected for REFRESH_DIV clocks; the display blinks with a
// half-period of BLINK_FRAMES complete scan frames when blink_en is set.
module hex_scan_driver #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    hex_scan_if.slave  bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic {
        PHASE_ON  = 1'b0,
        PHASE_OFF = 1'b1
    } phase_t;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] encode(input logic [3:0] nib);
        case (nib)
            4'h0:    encode = 7'b1000000;
            4'h1:    encode = 7'b1111001;
            4'h2:    encode = 7'b0100100;
            4'h3:    encode = 7'b0110000;
            4'h4:    encode = 7'b0011001;
            4'h5:    encode = 7'b0010010;
            4'h6:    encode = 7'b0000010;
            4'h7:    encode = 7'b1111000;
            4'h8:    encode = 7'b0000000;
            4'h9:    encode = 7'b0010000;
            4'hA:    encode = 7'b0001000;
            4'hB:    encode = 7'b0000011;
            4'hC:    encode = 7'b0100111;
            4'hD:    encode = 7'b0100001;
            4'hE:    encode = 7'b0000110;
            default: encode = 7'b0001110;
        endcase
    endfunction

    logic [4*DIGITS-1:0] shadow;
    logic [PRE_W-1:0]    presc;
    logic [IDX_W-1:0]    idx;
    logic [BLK_W-1:0]    blink_cnt;
    phase_t              phase;

    logic [6:0]          seg_q;
    logic [DIGITS-1:0]   sel_q;
    logic                tick_q;

    logic                presc_tc;
    logic                last_digit;
    logic                wrap;
    logic [3:0]          nib;
    logic [DIGITS-1:0]   sel_cur;
    logic [DIGITS-1:0]   lz_mask;
    logic                zero_run;
    logic                lz_hit;
    logic                blink_off;
    logic [6:0]          seg_next;
    logic [DIGITS-1:0]   sel_next;

    assign presc_tc   = (presc == PRE_W'(REFRESH_DIV - 1));
    assign last_digit = (idx == IDX_W'(DIGITS - 1));
    assign wrap       = presc_tc && last_digit;

    // Decode the scan index into a nibble and an active-low select.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path
        // leaves it unassigned, which would otherwise infer a latch.
        nib     = 4'h0;
        sel_cur = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nib        = shadow[4*i +: 4];
                sel_cur[i] = 1'b0;
            end
        end
    end

    // lz_mask[i] is set when nibbles DIGITS-1 down to i are all zero.
    // Digit 0 is never part of the mask so a zero value still shows "0".
    always_comb begin
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run && (shadow[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_run;
        end
    end

    assign lz_hit    = |(lz_mask & ~sel_cur);
    assign blink_off = bus.blink_en && (phase == PHASE_OFF);

    always_comb begin
        if (blink_off) begin
            seg_next = 7'b1111111;
            sel_next = '1;
        end else begin
            seg_next = (bus.blank_lz && lz_hit) ? 7'b1111111 : encode(nib);
            sel_next = sel_cur;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow    <= '0;
            presc     <= '0;
            idx       <= '0;
            blink_cnt <= '0;
            phase     <= PHASE_ON;
            seg_q     <= 7'b1111111;
            sel_q     <= '1;
            tick_q    <= 1'b0;
        end else begin
            if (bus.load) begin
                shadow <= bus.value;
            end

            if (presc_tc) begin
                presc <= '0;
                idx   <= last_digit ? '0 : idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end

            // Blink timing advances on the same edge that raises frame_tick,
            // so each phase lasts exactly BLINK_FRAMES frames; it keeps
            // running while blink_en is low.
            if (wrap) begin
                if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
                    blink_cnt <= '0;
                    phase     <= (phase == PHASE_ON) ? PHASE_OFF : PHASE_ON;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end

            seg_q  <= seg_next;
            sel_q  <= sel_next;
            tick_q <= wrap;
        end
    end

    assign bus.seg_out    = seg_q;
    assign bus.digit_sel  = sel_q;
    assign bus.frame_tick = tick_q;
endmodule

// File: doc/hex_scan_driver.md
Name: hex_scan_driver

Overview:
- Parametrised, time-multiplexed driver for N common-anode 7-segment hex digits, behind one shared active-low segment bus.
- Captures an N-nibble value on a load strobe and scans one digit at a time at a programmable refresh rate.
- Adds optional leading-zero blanking and whole-display blink.
- Sits between datapath debug outputs (ALU result, register file taps) and the board's display pins.

Parameters:
- DIGITS, 4, number of hex digits scanned (legal 1..8).
- REFRESH_DIV, 50000, clk cycles each digit stays selected (legal >= 2).
- BLINK_FRAMES, 64, complete scan frames per blink half-period (legal >= 1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- value  input  4*DIGITS  hex value to display; nibble i drives digit i, digit 0 = least significant.
- load  input  1  when high on a clock edge, value is captured into the shadow register.
- blank_lz  input  1  enables leading-zero blanking.
- blink_en  input  1  enables display blink.
- seg_out  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- digit_sel  output  DIGITS  digit enables, active-low one-hot, registered.
- frame_tick  output  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.

Behaviour:
- Reset (rst high at an edge):
  - shadow=0, prescaler=0, digit index=0, blink counter=0, blink phase=ON.
  - seg_out=7'b1111111, digit_sel=all ones, frame_tick=0.
  - rst has priority over load and all counting.
- Shadow register:
  - load=1 captures value at that edge.
  - Displayed data always comes from shadow, never directly from value.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - At terminal count, digit index advances by 1 and wraps from DIGITS-1 to 0.
  - Index register width is max(1, clog2(DIGITS)).
- frame_tick:
  - Asserted for exactly the cycle in which the index wraps DIGITS-1 -> 0.
  - With DIGITS=1 it pulses every REFRESH_DIV cycles.
- Blink:
  - The blink counter increments on each frame_tick.
  - When it reaches BLINK_FRAMES-1 and a frame_tick occurs, the counter clears and the blink phase toggles.
  - The counter runs regardless of blink_en.
  - Deasserting blink_en takes effect on the next output register update.
- Output register:
  - Updated every cycle from the current index, shadow, blink phase and mode inputs.
  - Latency is 1 cycle from an index, shadow or mode change to the pins.
  - digit_sel = ~(1 << index).
  - seg_out = encode(nibble[index]), active-low:
    0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, c=0100111, d=0100001, E=0000110, F=0001110.
- Leading-zero blanking:
  - When blank_lz=1, digit i (i>0) is blanked if nibbles DIGITS-1 down to i are all zero.
  - Digit 0 is never blanked, so a value of 0 displays "0".
  - A blanked digit drives seg_out=1111111; digit_sel still follows the scan.
- Blink-off phase: when blink_en=1 and phase=OFF, seg_out=1111111 and digit_sel=all ones.
- load in the same cycle as an index advance: the new shadow is used from the next cycle, with the usual 1-cycle pin latency.
- Reset mid-scan: outputs go fully dark for one cycle, then the scan restarts at digit 0 with the prescaler cleared.

Test Plan (DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2 unless noted):
- Reset check: hold rst 2 cycles -> seg_out=1111111, digit_sel=1111, frame_tick=0. On the first post-reset edge -> digit_sel=1110, seg_out=1000000.
- Scan order: load value=16'h1A3F, no blanking -> digits 0..3 show 0001110, 0110000, 0001000, 1111001 (F,3,A,1). Each digit is held 4 cycles; digit_sel goes 1110,1101,1011,0111; frame_tick pulses once per 16 cycles at the 3->0 wrap.
- Leading-zero blanking: load 16'h0050 with blank_lz=1 -> digit 3 and digit 2 show 1111111, digit 1 shows 0010010, digit 0 shows 1000000. Load 16'h0000 -> only digit 0 shows 1000000.
- Blink: blink_en=1, value 16'h8888 -> segments show 0000000 for 2 frames (32 cycles), then all-dark (digit_sel=1111) for 32 cycles, repeating. Dropping blink_en restores the display within 1 cycle.
- Load boundary: assert load with 16'h0001 in the cycle the index wraps to 0 -> the next digit 0 output is 1111001. Value changes without load leave the display unchanged.
- Reset mid-operation: assert rst while digit 2 is active -> the next cycle is dark. After release, the scan restarts at digit 0 with a full 4-cycle dwell, and the shadow is cleared to 0.
